// File: rtl/plcp_framer.sv
// Serial 802.11b long-preamble PLCP framer: SYNC, SFD, SIGNAL/SERVICE/LENGTH + CRC-16,
// then PSDU bytes from a one-entry holding buffer, one bit per trigger strobe, LSB first.
//
// state     | meaning
// S_IDLE    | waiting for an accepted start
// S_SYNC    | emitting SYNC_BITS ones
// S_SFD     | emitting 16'hF3A0, bit 0 first
// S_HDR     | emitting SIGNAL, SERVICE, LENGTH, then the complemented CRC-16
// S_PAYLOAD | emitting PSDU bytes, LSB first
// S_STOP    | final bit is on the line; the next strobe closes the frame
module plcp_framer #(
    parameter int         SYNC_BITS    = 128,
    parameter logic [7:0] SIGNAL_CODE  = 8'h0A,
    parameter logic [7:0] SERVICE_CODE = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic        start,
    input  logic [15:0] length_us,
    input  logic [11:0] payload_bytes,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        output_data,
    output logic        output_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);

    localparam int CW = ($clog2(SYNC_BITS) > 6) ? $clog2(SYNC_BITS) : 6;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SYNC    = 3'd1;
    localparam logic [2:0] S_SFD     = 3'd2;
    localparam logic [2:0] S_HDR     = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_STOP    = 3'd5;

    localparam logic [15:0]   SFD_WORD  = 16'hF3A0;
    localparam logic [15:0]   CRC_POLY  = 16'h1021;
    localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_BITS - 1);
    localparam logic [CW-1:0] SFD_LAST  = CW'(15);
    localparam logic [CW-1:0] HDR_LAST  = CW'(47);

    logic [2:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [15:0]   crc;
    logic [15:0]   length_q;
    logic [11:0]   byte_left;
    logic [11:0]   fetch_left;
    logic [7:0]    hold_buf;
    logic          buf_full;
    logic [7:0]    shift_reg;

    logic [31:0] hdr_word;
    logic        xfer;
    logic        step;
    logic        boundary;
    logic        starve;
    logic        start_ok;
    logic        hdr_bit;
    logic        crc_fb;
    logic [7:0]  byte_now;

    assign hdr_word   = {length_q, SERVICE_CODE, SIGNAL_CODE};
    assign busy       = (state != S_IDLE);
    assign byte_ready = ((state == S_HDR) || (state == S_PAYLOAD)) && !buf_full
                        && (fetch_left != 12'd0);
    assign xfer       = byte_valid & byte_ready;
    // frame_done marks the first IDLE cycle, in which a new start is still refused
    assign start_ok   = start && (state == S_IDLE) && !frame_done;
    assign step       = trigger && busy;
    assign boundary   = step && (state == S_PAYLOAD) && (bit_cnt[2:0] == 3'd0);
    assign starve     = boundary && !buf_full && !xfer;
    // a byte arriving on the boundary strobe itself bypasses the empty buffer
    assign byte_now   = buf_full ? hold_buf : (xfer ? byte_data : 8'h00);
    assign hdr_bit    = hdr_word[bit_cnt[4:0]];
    assign crc_fb     = crc[15] ^ hdr_bit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            crc          <= 16'hFFFF;
            length_q     <= '0;
            byte_left    <= '0;
            fetch_left   <= '0;
            hold_buf     <= '0;
            buf_full     <= 1'b0;
            shift_reg    <= '0;
            output_data  <= 1'b0;
            output_valid <= 1'b0;
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (start_ok) begin
                state      <= S_SYNC;
                bit_cnt    <= '0;
                crc        <= 16'hFFFF;
                length_q   <= length_us;
                byte_left  <= payload_bytes;
                fetch_left <= payload_bytes;
                buf_full   <= 1'b0;
                underrun   <= 1'b0;
            end else begin
                // a starved slot consumes one fetch so late bytes land in the next slot
                if (xfer || starve) begin
                    fetch_left <= fetch_left - 12'd1;
                end
                if (boundary) begin
                    buf_full <= 1'b0;
                end else if (xfer) begin
                    buf_full <= 1'b1;
                    hold_buf <= byte_data;
                end

                if (step) begin
                    output_valid <= 1'b1;
                    case (state)
                        S_SYNC: begin
                            output_data <= 1'b1;
                            if (bit_cnt == SYNC_LAST) begin
                                bit_cnt <= '0;
                                state   <= S_SFD;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        S_SFD: begin
                            output_data <= SFD_WORD[bit_cnt[3:0]];
                            if (bit_cnt == SFD_LAST) begin
                                bit_cnt <= '0;
                                state   <= S_HDR;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        S_HDR: begin
                            if (!bit_cnt[5]) begin
                                output_data <= hdr_bit;
                                crc <= {crc[14:0], 1'b0} ^ (crc_fb ? CRC_POLY : 16'h0000);
                            end else begin
                                output_data <= ~crc[15];
                                crc <= {crc[14:0], 1'b1};
                            end
                            if (bit_cnt == HDR_LAST) begin
                                bit_cnt <= '0;
                                state   <= (byte_left == 12'd0) ? S_STOP : S_PAYLOAD;
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        S_PAYLOAD: begin
                            if (bit_cnt[2:0] == 3'd0) begin
                                output_data <= byte_now[0];
                                shift_reg   <= {1'b0, byte_now[7:1]};
                                if (starve) begin
                                    underrun <= 1'b1;
                                end
                            end else begin
                                output_data <= shift_reg[0];
                                shift_reg   <= {1'b0, shift_reg[7:1]};
                            end
                            if (bit_cnt[2:0] == 3'd7) begin
                                bit_cnt   <= '0;
                                byte_left <= byte_left - 12'd1;
                                if (byte_left == 12'd1) begin
                                    state <= S_STOP;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                        S_STOP: begin
                            output_data  <= 1'b0;
                            output_valid <= 1'b0;
                            frame_done   <= 1'b1;
                            state        <= S_IDLE;
                        end
                        default: begin
                            state <= S_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_plcp_framer.sv
// Bench for plcp_framer: two instances (SERVICE 8'h00 and 8'h04) share stimulus and are
// compared bit by bit against a frame model built from the field/CRC rules.
`timescale 1ns/1ps
module tb_plcp_framer;

    typedef struct packed {
        logic [15:0]      len;
        logic [11:0]      nbytes;
        int               gap;
        logic             trig_ws;
        logic [3:0][7:0]  data;
        logic [3:0][15:0] av;
        int               start_mid;
        logic             start_done;
        int               abort_at;
        int               exp_valid;
        int               exp_under;
    } frame_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        trigger;
    logic        start;
    logic [15:0] length_us;
    logic [11:0] payload_bytes;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        ready_a, data_a, valid_a, busy_a, done_a, under_a;
    logic        ready_b, data_b, valid_b, busy_b, done_b, under_b;

    int     n_tests = 0;
    int     n_fail  = 0;
    logic   hb [2][192];
    frame_t tbl [7];

    always #5 clock = ~clock;

    plcp_framer dut_a (
        .clock(clock), .reset(reset), .trigger(trigger), .start(start),
        .length_us(length_us), .payload_bytes(payload_bytes),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(ready_a),
        .output_data(data_a), .output_valid(valid_a), .busy(busy_a),
        .frame_done(done_a), .underrun(under_a)
    );

    plcp_framer #(.SERVICE_CODE(8'h04)) dut_b (
        .clock(clock), .reset(reset), .trigger(trigger), .start(start),
        .length_us(length_us), .payload_bytes(payload_bytes),
        .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(ready_b),
        .output_data(data_b), .output_valid(valid_b), .busy(busy_b),
        .frame_done(done_b), .underrun(under_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected SYNC/SFD/header/CRC bit stream, in transmit order
    task automatic build_hdr(input int w, input logic [7:0] svc, input logic [15:0] len);
        logic [15:0] sfd;
        logic [31:0] fields;
        logic [15:0] c;
        logic        fb;
        sfd    = 16'hF3A0;
        fields = {len, svc, 8'h0A};
        c      = 16'hFFFF;
        for (int i = 0; i < 128; i++) hb[w][i] = 1'b1;
        for (int i = 0; i < 16; i++) hb[w][128 + i] = sfd[i];
        for (int i = 0; i < 32; i++) begin
            hb[w][144 + i] = fields[i];
            fb = c[15] ^ fields[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        for (int i = 0; i < 16; i++) hb[w][176 + i] = ~c[15 - i];
    endtask

    function automatic frame_t mk(input logic [15:0] len, input logic [11:0] nb, input int gap,
                                  input logic tws, input logic [31:0] data, input logic [63:0] av,
                                  input int smid, input logic sdone, input int abort,
                                  input int ev, input int eu);
        frame_t f;
        f.len = len; f.nbytes = nb; f.gap = gap; f.trig_ws = tws;
        f.data = data; f.av = av; f.start_mid = smid; f.start_done = sdone;
        f.abort_at = abort; f.exp_valid = ev; f.exp_under = eu;
        return f;
    endfunction

    task automatic run_frame(input frame_t f, input string tag);
        int         n_bits, s, c, nxt, xfers, unders, valid_seen, p;
        logic [7:0] q[$];
        logic [7:0] cur;
        logic       exp_under, exp_rdy, xfer, mid_done, last_a, last_b, ea, eb;
        logic       done, aborted;

        n_bits = 192 + 8 * int'(f.nbytes);
        build_hdr(0, 8'h00, f.len);
        build_hdr(1, 8'h04, f.len);
        s = 0; c = 0; nxt = 0; xfers = 0; unders = 0; valid_seen = 0;
        cur = 8'h00; exp_under = 1'b0; mid_done = 1'b0;
        last_a = 1'b0; last_b = 1'b0; done = 1'b0; aborted = 1'b0;

        @(negedge clock);
        start = 1'b1; length_us = f.len; payload_bytes = f.nbytes;
        trigger = f.trig_ws; byte_valid = 1'b0;
        @(posedge clock); #1;
        check($sformatf("%s start", tag),
              {busy_a, busy_b, valid_a, valid_b, data_a, data_b, under_a, under_b, done_a, done_b},
              32'b1100000000);

        while (!done) begin
            @(negedge clock);
            exp_rdy = (s >= 144) && (s < n_bits) && (q.size() == 0)
                      && ((xfers + unders) < int'(f.nbytes));
            check($sformatf("%s byte_ready s=%0d", tag, s), {ready_a, ready_b}, {2{exp_rdy}});
            start   = 1'b0;
            trigger = ((c % f.gap) == (f.gap - 1));
            if (f.start_mid != 0 && s == f.start_mid && !mid_done) begin
                start = 1'b1; length_us = 16'hFFFF; payload_bytes = 12'hFFF; mid_done = 1'b1;
            end
            byte_valid = 1'b0;
            byte_data  = 8'h00;
            if (nxt < int'(f.nbytes)) begin
                if (s >= int'(f.av[nxt])) begin
                    byte_valid = 1'b1;
                    byte_data  = f.data[nxt];
                end
            end
            xfer = byte_valid && ready_a;
            @(posedge clock); #1;
            if (xfer) begin
                q.push_back(byte_data);
                xfers++;
                nxt++;
            end
            if (trigger) begin
                s++;
                if (s <= n_bits) begin
                    if (s <= 192) begin
                        ea = hb[0][s - 1];
                        eb = hb[1][s - 1];
                    end else begin
                        p = s - 193;
                        if (p % 8 == 0) begin
                            if (q.size() > 0) cur = q.pop_front();
                            else begin
                                cur = 8'h00;
                                unders++;
                                exp_under = 1'b1;
                            end
                        end
                        ea = cur[p % 8];
                        eb = ea;
                    end
                    if (valid_a) valid_seen++;
                    check($sformatf("%s bit s=%0d", tag, s), {data_a, data_b}, {ea, eb});
                    check($sformatf("%s ctl s=%0d", tag, s),
                          {valid_a, valid_b, busy_a, busy_b, done_a, done_b}, 32'b111100);
                    last_a = ea;
                    last_b = eb;
                end else begin
                    check($sformatf("%s close", tag),
                          {data_a, data_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b},
                          32'b00000011);
                    done = 1'b1;
                end
            end else begin
                check($sformatf("%s hold s=%0d", tag, s),
                      {data_a, data_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b},
                      {24'd0, last_a, last_b, (s >= 1), (s >= 1), 4'b1100});
            end
            check($sformatf("%s underrun s=%0d", tag, s), {under_a, under_b}, {2{exp_under}});
            if (f.abort_at != 0 && s == f.abort_at) begin
                aborted = 1'b1;
                done    = 1'b1;
            end
            c++;
            if (!done && c > 4000) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s timeout: %0d strobes seen, %0d required", tag, s, n_bits + 1);
                done = 1'b1;
            end
        end

        trigger    = 1'b0;
        byte_valid = 1'b0;
        start      = 1'b0;

        if (aborted) begin
            @(negedge clock);
            #2 reset = 1'b1;
            #1;
            check($sformatf("%s async reset", tag),
                  {data_a, valid_a, busy_a, done_a, under_a, ready_a,
                   data_b, valid_b, busy_b, done_b, under_b, ready_b}, 32'd0);
            @(negedge clock);
            reset = 1'b0;
        end else begin
            // frame_done cycle: a start or strobe here must have no effect
            @(negedge clock);
            trigger = 1'b1;
            start   = f.start_done;
            length_us = 16'hA5A5; payload_bytes = 12'h005;
            @(posedge clock); #1;
            check($sformatf("%s after done", tag),
                  {data_a, data_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b}, 32'd0);
            check($sformatf("%s underrun sticky", tag), {under_a, under_b}, {2{exp_under}});
            start   = 1'b0;
            trigger = 1'b0;
            if (f.exp_valid >= 0)
                check($sformatf("%s valid strobes", tag), valid_seen, f.exp_valid);
            if (f.exp_under >= 0)
                check($sformatf("%s underrun final", tag), {31'd0, under_a}, f.exp_under);
            check($sformatf("%s fetch bound", tag), {31'd0, (xfers + unders) <= int'(f.nbytes)}, 1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        reset = 1'b1; trigger = 1'b0; start = 1'b0; length_us = '0;
        payload_bytes = '0; byte_data = '0; byte_valid = 1'b0;
        repeat (2) @(negedge clock);
        check("reset state",
              {data_a, valid_a, busy_a, done_a, under_a, ready_a,
               data_b, valid_b, busy_b, done_b, under_b, ready_b}, 32'd0);
        reset = 1'b0;

        //          len       nb  gap tws data          av (byte3..byte0)                    smid done abort ev  eu
        tbl[0] = mk(16'h1234, 0,  4,  0,  32'h0,        64'h0,                                0,   0,   0,   192, 0);
        tbl[1] = mk(16'h0040, 2,  2,  0,  32'h000001A5, 64'h0,                                0,   0,   0,   208, 0);
        tbl[2] = mk(16'h0055, 3,  1,  0,  32'h00003C5A, {16'd0, 16'd0, 16'd203, 16'd0},       196, 1,   0,   216, 1);
        tbl[3] = mk(16'h0100, 1,  3,  0,  32'h000000C3, 64'h0,                                0,   0,   0,   200, 0);
        tbl[4] = mk(16'hBEEF, 2,  2,  0,  32'h0000FFEE, 64'h0,                                0,   0,   160, -1,  -1);
        tbl[5] = mk(16'h0100, 2,  3,  0,  32'h00008001, 64'h0,                                0,   0,   0,   208, 0);
        tbl[6] = mk(16'h0777, 1,  1,  1,  32'h00000077, {16'd0, 16'd0, 16'd0, 16'd192},      0,   0,   0,   200, 0);

        for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            frame_t f;
            nb = $urandom_range(0, 4);
            f = mk(16'($urandom), 12'(nb), $urandom_range(1, 3), 1'($urandom_range(0, 1)),
                   $urandom,
                   {16'($urandom_range(0, 240)), 16'($urandom_range(0, 240)),
                    16'($urandom_range(0, 240)), 16'($urandom_range(0, 240))},
                   0, 1'($urandom_range(0, 1)), 0, 192 + 8 * nb, -1);
            run_frame(f, $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
